dark_soc_v: RTL and testbench
=============================

# dark_soc_v

Top-level SoC shell for the DarkRISCV board builds: owns the board clock and reset, and the serial console. After reset it transmits a fixed boot banner over an 8N1 UART, then echoes every correctly framed received byte back to the host. It is the single DUT instantiated by the board-level bench: clock on XCLK, reset on XRES, console on UART_RXD/UART_TXD.

## Interface
- BOARD_CK, 100000000, board clock frequency in Hz.
- BAUD, 115200, UART bit rate; divisor DIV = BOARD_CK/BAUD, truncated (868 at defaults).
- XCLK  input  1  board clock; all logic on rising edge.
- XRES  input  1  reset; synchronous, active-high.
- UART_RXD  input  1  serial receive; idles high; asynchronous to XCLK.
- UART_TXD  output  1  serial transmit; idles high.

## Operation
- Reset (XRES=1 at a rising edge):
  - UART_TXD=1, all state cleared.
  - Banner pointer = 0; RX holding buffer empty.
  - Reset asserted mid-frame aborts it; TXD returns high on that edge.
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); no parity.
- Banner: 9 bytes from internal ROM: 0x64 0x61 0x72 0x6B 0x73 0x6F 0x63 0x76 0x0A ("darksocv\n"). Sent once per reset, back-to-back, no idle gap between frames.
- States:
  - BOOT: sending banner; goes to RUN after the stop bit of 0x0A.
  - RUN: TX idle; starts a frame whenever the RX holding buffer is full.
  - Stays in RUN until reset.
- RX input:
  - UART_RXD passes through a 2-flop synchronizer.
  - A falling edge on the synchronized line while the receiver is idle starts a frame.
  - Start bit is rechecked at DIV/2 cycles; if it reads high, the frame is aborted as a glitch.
  - Data bits are then sampled every DIV cycles; the stop bit is sampled one DIV after the last data bit.
  - Stop bit = 0: framing error, byte discarded.
- RX holding buffer (1 byte):
  - A valid byte is stored if the buffer is empty.
  - If the buffer is full, the new byte is dropped and the held byte is kept.
  - The buffer empties on the cycle its byte is loaded into the TX shifter.
- Bytes received during BOOT are held and echoed after the banner completes.
- The receiver operates in both states and is independent of TX activity (full duplex).

## Timing
- Every TX bit lasts exactly DIV cycles.
- Frame = 10*DIV cycles; banner = 90*DIV cycles (78120 at defaults).
- Banner start: UART_TXD falls on the 2nd rising edge after the first edge sampling XRES=0.
- Echo latency:
  - Echo start bit begins at most 3 cycles after the RX stop-bit sample, if TX is idle.
  - Otherwise it begins immediately after the current stop bit ends.
- RX tolerance: accepts ±3% bit-rate error relative to DIV.
- No combinational path from UART_RXD to UART_TXD; UART_TXD is driven directly from a flop.

## Configuration
- UART_ECHO_EN defined: receiver, holding buffer and echo path are compiled in; behaviour as above.
- UART_ECHO_EN undefined:
  - Receiver logic is removed and UART_RXD is ignored.
  - After the banner, UART_TXD stays high until the next reset.

## Test plan
- Reset held 1 µs, RXD=1, defaults -> TXD=1 during reset; TXD falls 2 edges after release; decoded bytes are "darksocv\n"; each bit is 868 cycles; TXD stays high after 78120 cycles.
- Reassert XRES during the 4th banner byte, then release -> TXD high on that edge; banner restarts from 0x64.
- After the banner, send 0x55 then 0xA3 on RXD at 115200 -> TXD echoes 0x55 then 0xA3; each echo start bit within 3 cycles of the RX stop sample, or back-to-back after the previous frame.
- Send 0x41 during BOOT, then 0x42 also during BOOT -> full banner first, then exactly one echo of 0x41; 0x42 dropped.
- Stop bit forced to 0 on 0x7E; separately a 0.3-bit-long low glitch on RXD -> no echo in either case; a following 0x31 is echoed correctly.
- Build without UART_ECHO_EN, send 0x55 after the banner -> TXD remains high.

Source files
------------

// File: rtl/dark_soc_v.sv
// DarkRISCV board SoC shell: 8N1 UART that sends a boot banner, then echoes received bytes.
// Define UART_ECHO_EN to build in the receiver, the holding buffer and the echo path.
module dark_soc_v #(
  parameter int unsigned BOARD_CK = 100000000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic XCLK,
  input  logic XRES,
  input  logic UART_RXD,
  output logic UART_TXD
);

  localparam int unsigned DIV     = BOARD_CK / BAUD;
  localparam int unsigned HALF    = DIV / 2;
  localparam int unsigned CW      = $clog2(DIV + 1);
  localparam int unsigned NBANNER = 9;

  typedef enum logic {S_BOOT, S_RUN} tx_state_e;

  function automatic logic [7:0] banner_byte(input logic [3:0] idx);
    case (idx)
      4'd0:    banner_byte = 8'h64;
      4'd1:    banner_byte = 8'h61;
      4'd2:    banner_byte = 8'h72;
      4'd3:    banner_byte = 8'h6B;
      4'd4:    banner_byte = 8'h73;
      4'd5:    banner_byte = 8'h6F;
      4'd6:    banner_byte = 8'h63;
      4'd7:    banner_byte = 8'h76;
      4'd8:    banner_byte = 8'h0A;
      default: banner_byte = 8'h00;
    endcase
  endfunction

  tx_state_e       state_q;
  logic [3:0]      ptr_q;
  logic [1:0]      boot_dly_q;
  logic            tx_busy_q;
  logic [8:0]      tx_shift_q;
  logic [3:0]      tx_bit_q;
  logic [CW-1:0]   tx_cnt_q;
  logic            txd_q;

  logic            hold_valid_c;
  logic [7:0]      hold_data_c;
  logic            frame_end_c;
  logic            tx_free_c;
  logic            banner_load_c;
  logic            echo_load_c;

  assign UART_TXD = txd_q;

  // Load decisions: a new frame may start on the same edge the previous stop bit ends.
  always_comb begin
    frame_end_c   = 1'b0;
    tx_free_c     = 1'b0;
    banner_load_c = 1'b0;
    echo_load_c   = 1'b0;
    frame_end_c   = tx_busy_q && (tx_cnt_q == CW'(DIV - 1)) && (tx_bit_q == 4'd9);
    tx_free_c     = !tx_busy_q || frame_end_c;
    banner_load_c = (state_q == S_BOOT) && (ptr_q != 4'(NBANNER)) && tx_free_c &&
                    (tx_busy_q || boot_dly_q[1]);
    echo_load_c   = (state_q == S_RUN) && hold_valid_c && tx_free_c;
  end

  // TX shifter and BOOT/RUN sequencing.
  always_ff @(posedge XCLK) begin
    if (XRES) begin
      state_q    <= S_BOOT;
      ptr_q      <= '0;
      boot_dly_q <= '0;
      tx_busy_q  <= 1'b0;
      tx_shift_q <= '1;
      tx_bit_q   <= '0;
      tx_cnt_q   <= '0;
      txd_q      <= 1'b1;
    end else begin
      boot_dly_q <= {boot_dly_q[0], 1'b1};
      if (banner_load_c || echo_load_c) begin
        txd_q      <= 1'b0;
        tx_shift_q <= {1'b1, (banner_load_c ? banner_byte(ptr_q) : hold_data_c)};
        tx_bit_q   <= '0;
        tx_cnt_q   <= '0;
        tx_busy_q  <= 1'b1;
        if (banner_load_c) begin
          ptr_q <= ptr_q + 4'd1;
        end
      end else if (frame_end_c) begin
        tx_busy_q <= 1'b0;
        tx_cnt_q  <= '0;
        txd_q     <= 1'b1;
        if (state_q == S_BOOT) begin
          state_q <= S_RUN;
        end
      end else if (tx_busy_q) begin
        if (tx_cnt_q == CW'(DIV - 1)) begin
          tx_cnt_q   <= '0;
          txd_q      <= tx_shift_q[0];
          tx_shift_q <= {1'b1, tx_shift_q[8:1]};
          tx_bit_q   <= tx_bit_q + 4'd1;
        end else begin
          tx_cnt_q <= tx_cnt_q + CW'(1);
        end
      end
    end
  end

`ifdef UART_ECHO_EN
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_e;

  rx_state_e       rx_state_q;
  logic            rx_meta_q;
  logic            rx_sync_q;
  logic            rx_prev_q;
  logic [CW-1:0]   rx_cnt_q;
  logic [2:0]      rx_bit_q;
  logic [7:0]      rx_shift_q;
  logic            hold_valid_q;
  logic [7:0]      hold_data_q;

  assign hold_valid_c = hold_valid_q;
  assign hold_data_c  = hold_data_q;

  // Receiver: start bit rechecked mid-bit, data and stop sampled at bit centres.
  always_ff @(posedge XCLK) begin
    if (XRES) begin
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      rx_prev_q    <= 1'b1;
      rx_state_q   <= R_IDLE;
      rx_cnt_q     <= '0;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
    end else begin
      rx_meta_q <= UART_RXD;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      if (echo_load_c) begin
        hold_valid_q <= 1'b0;
      end
      case (rx_state_q)
        R_IDLE: begin
          rx_cnt_q <= '0;
          if (rx_prev_q && !rx_sync_q) begin
            rx_state_q <= R_START;
          end
        end
        R_START: begin
          if (rx_cnt_q == CW'(HALF - 1)) begin
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_state_q <= rx_sync_q ? R_IDLE : R_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + CW'(1);
          end
        end
        R_DATA: begin
          if (rx_cnt_q == CW'(DIV - 1)) begin
            rx_cnt_q   <= '0;
            rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
            rx_bit_q   <= rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) begin
              rx_state_q <= R_STOP;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + CW'(1);
          end
        end
        R_STOP: begin
          if (rx_cnt_q == CW'(DIV - 1)) begin
            rx_cnt_q   <= '0;
            rx_state_q <= R_IDLE;
            // A full buffer keeps its byte; a low stop bit discards the frame.
            if (rx_sync_q && !hold_valid_q) begin
              hold_data_q  <= rx_shift_q;
              hold_valid_q <= 1'b1;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + CW'(1);
          end
        end
        default: rx_state_q <= R_IDLE;
      endcase
    end
  end
`else
  logic unused_rxd;

  assign unused_rxd   = UART_RXD;
  assign hold_valid_c = 1'b0;
  assign hold_data_c  = 8'h00;
`endif

endmodule

// File: tb/tb_dark_soc_v.sv
// Directed bench for dark_soc_v at DIV=16: banner, reset abort, echo and RX error cases.
module tb_dark_soc_v;

  localparam int unsigned DIV = 16;

  logic XCLK = 1'b0;
  logic XRES = 1'b1;
  logic UART_RXD = 1'b1;
  logic UART_TXD;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [7:0] banner [9] = '{8'h64, 8'h61, 8'h72, 8'h6B, 8'h73, 8'h6F, 8'h63, 8'h76, 8'h0A};

  always #5 XCLK = ~XCLK;
  always @(posedge XCLK) cyc <= cyc + 1;

  dark_soc_v #(.BOARD_CK(1600), .BAUD(100)) dut (
    .XCLK(XCLK),
    .XRES(XRES),
    .UART_RXD(UART_RXD),
    .UART_TXD(UART_TXD)
  );

  task automatic step(input int n);
    repeat (n) @(posedge XCLK);
    #1;
  endtask

  task automatic wait_fall(input int max, output bit found, output int at);
    found = 1'b0;
    at = 0;
    for (int i = 0; i <= max; i++) begin
      if (UART_TXD === 1'b0) begin
        found = 1'b1;
        at = cyc;
        break;
      end
      step(1);
    end
  endtask

  // Called on the first cycle of a start bit; returns on the first cycle after the stop bit.
  task automatic capture_frame(output logic [9:0] bits, output bit width_ok);
    logic v0, v1;
    width_ok = 1'b1;
    bits = '0;
    for (int k = 0; k < 10; k++) begin
      v0 = UART_TXD;
      step(DIV - 1);
      v1 = UART_TXD;
      if (v0 !== v1) width_ok = 1'b0;
      bits[k] = v0;
      step(1);
    end
  endtask

  task automatic count_low(input int n, output int lows);
    lows = 0;
    repeat (n) begin
      if (UART_TXD !== 1'b1) lows++;
      step(1);
    end
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_b, output int t0);
    t0 = cyc;
    UART_RXD = 1'b0;
    step(DIV);
    for (int k = 0; k < 8; k++) begin
      UART_RXD = b[k];
      step(DIV);
    end
    UART_RXD = stop_b;
    step(DIV);
    UART_RXD = 1'b1;
  endtask

  task automatic test_reset();
    int lows;
    XRES = 1'b1;
    UART_RXD = 1'b1;
    step(10);
    count_low(90, lows);
    checks++;
    if (lows !== 0) begin
      failures++;
      $display("FAIL reset_txd_high: low cycles=%0d expected 0", lows);
    end
    XRES = 1'b0;
    step(1);
    checks++;
    if (UART_TXD !== 1'b1) begin
      failures++;
      $display("FAIL release_edge0: txd=%b expected 1", UART_TXD);
    end
    step(1);
    checks++;
    if (UART_TXD !== 1'b1) begin
      failures++;
      $display("FAIL release_edge1: txd=%b expected 1", UART_TXD);
    end
    step(1);
    checks++;
    if (UART_TXD !== 1'b0) begin
      failures++;
      $display("FAIL banner_start_edge2: txd=%b expected 0", UART_TXD);
    end
  endtask

  task automatic test_reset_midframe();
    logic [9:0] bits;
    bit wok;
    for (int i = 0; i < 3; i++) begin
      capture_frame(bits, wok);
      checks++;
      if (bits !== {1'b1, banner[i], 1'b0} || !wok) begin
        failures++;
        $display("FAIL pre_abort_byte%0d: got %h width_ok=%b expected %h", i, bits, wok,
                 {1'b1, banner[i], 1'b0});
      end
    end
    step(3 * DIV + 4);
    checks++;
    if (UART_TXD !== 1'b0) begin
      failures++;
      $display("FAIL byte3_data_bit2: txd=%b expected 0", UART_TXD);
    end
    XRES = 1'b1;
    step(1);
    checks++;
    if (UART_TXD !== 1'b1) begin
      failures++;
      $display("FAIL abort_txd_high: txd=%b expected 1", UART_TXD);
    end
    step(10);
    XRES = 1'b0;
    step(2);
    checks++;
    if (UART_TXD !== 1'b1) begin
      failures++;
      $display("FAIL restart_idle: txd=%b expected 1", UART_TXD);
    end
    step(1);
    checks++;
    if (UART_TXD !== 1'b0) begin
      failures++;
      $display("FAIL restart_start: txd=%b expected 0", UART_TXD);
    end
    capture_frame(bits, wok);
    checks++;
    if (bits !== {1'b1, 8'h64, 1'b0} || !wok) begin
      failures++;
      $display("FAIL restart_first_byte: got %h width_ok=%b expected %h", bits, wok,
               {1'b1, 8'h64, 1'b0});
    end
  endtask

  task automatic test_banner();
    logic [9:0] bits;
    bit wok;
    int lows;
    for (int i = 1; i < 9; i++) begin
      capture_frame(bits, wok);
      checks++;
      if (bits !== {1'b1, banner[i], 1'b0} || !wok) begin
        failures++;
        $display("FAIL banner_byte%0d: got %h width_ok=%b expected %h", i, bits, wok,
                 {1'b1, banner[i], 1'b0});
      end
    end
    count_low(200, lows);
    checks++;
    if (lows !== 0) begin
      failures++;
      $display("FAIL post_banner_idle: low cycles=%0d expected 0", lows);
    end
  endtask

`ifdef UART_ECHO_EN
  task automatic test_echo();
    int t0a, t0b, at1, at2;
    bit f1, f2, w1, w2;
    logic [9:0] b1, b2;
    b1 = '0;
    b2 = '0;
    w1 = 1'b0;
    w2 = 1'b0;
    fork
      begin
        send_rx(8'h55, 1'b1, t0a);
        send_rx(8'hA3, 1'b1, t0b);
      end
      begin
        wait_fall(400, f1, at1);
        if (f1) capture_frame(b1, w1);
        wait_fall(400, f2, at2);
        if (f2) capture_frame(b2, w2);
      end
    join
    checks++;
    if (!f1 || b1 !== {1'b1, 8'h55, 1'b0} || !w1) begin
      failures++;
      $display("FAIL echo_55: found=%b got %h width_ok=%b expected %h", f1, b1, w1,
               {1'b1, 8'h55, 1'b0});
    end
    checks++;
    if (at1 - t0a < 9 * DIV + DIV / 2 || at1 - t0a > 9 * DIV + DIV / 2 + 8) begin
      failures++;
      $display("FAIL echo_55_latency: start offset=%0d expected %0d..%0d", at1 - t0a,
               9 * DIV + DIV / 2, 9 * DIV + DIV / 2 + 8);
    end
    checks++;
    if (!f2 || b2 !== {1'b1, 8'hA3, 1'b0} || !w2) begin
      failures++;
      $display("FAIL echo_a3: found=%b got %h width_ok=%b expected %h", f2, b2, w2,
               {1'b1, 8'hA3, 1'b0});
    end
    checks++;
    if (at2 != at1 + 10 * DIV &&
        (at2 - t0b < 9 * DIV + DIV / 2 || at2 - t0b > 9 * DIV + DIV / 2 + 8)) begin
      failures++;
      $display("FAIL echo_a3_latency: start=%0d prev_start=%0d rx_start=%0d", at2, at1, t0b);
    end
  endtask

  task automatic test_boot_hold();
    int t0, lows, bad, at;
    bit f, wok, fe;
    logic [9:0] bits;
    bad = 0;
    lows = 0;
    fe = 1'b0;
    bits = '0;
    XRES = 1'b1;
    step(5);
    XRES = 1'b0;
    fork
      begin
        step(20);
        send_rx(8'h41, 1'b1, t0);
        send_rx(8'h42, 1'b1, t0);
      end
      begin
        wait_fall(10, f, at);
        for (int i = 0; i < 9; i++) begin
          capture_frame(bits, wok);
          if (bits !== {1'b1, banner[i], 1'b0} || !wok) bad++;
        end
        wait_fall(20, fe, at);
        if (fe) capture_frame(bits, wok);
        count_low(400, lows);
      end
    join
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL boot_banner_intact: bad frames=%0d expected 0", bad);
    end
    checks++;
    if (!fe || bits !== {1'b1, 8'h41, 1'b0}) begin
      failures++;
      $display("FAIL boot_held_echo: found=%b got %h expected %h", fe, bits,
               {1'b1, 8'h41, 1'b0});
    end
    checks++;
    if (lows !== 0) begin
      failures++;
      $display("FAIL boot_second_dropped: low cycles=%0d expected 0", lows);
    end
  endtask

  task automatic test_rx_errors();
    int t0, lows, at;
    bit f, wok;
    logic [9:0] bits;
    bits = '0;
    f = 1'b0;
    fork
      begin
        send_rx(8'h7E, 1'b0, t0);
        step(50);
        UART_RXD = 1'b0;
        step(5);
        UART_RXD = 1'b1;
        step(200);
        send_rx(8'h31, 1'b1, t0);
      end
      begin
        count_low(500, lows);
        wait_fall(200, f, at);
        if (f) capture_frame(bits, wok);
      end
    join
    checks++;
    if (lows !== 0) begin
      failures++;
      $display("FAIL framing_glitch_no_echo: low cycles=%0d expected 0", lows);
    end
    checks++;
    if (!f || bits !== {1'b1, 8'h31, 1'b0}) begin
      failures++;
      $display("FAIL echo_after_errors: found=%b got %h expected %h", f, bits,
               {1'b1, 8'h31, 1'b0});
    end
  endtask
`else
  task automatic test_no_echo();
    int t0, lows;
    fork
      send_rx(8'h55, 1'b1, t0);
      count_low(400, lows);
    join
    checks++;
    if (lows !== 0) begin
      failures++;
      $display("FAIL no_echo_txd_high: low cycles=%0d expected 0", lows);
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_reset_midframe();
    test_banner();
`ifdef UART_ECHO_EN
    test_echo();
    test_boot_hold();
    test_rx_errors();
`else
    test_no_echo();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
